ppu_rd_snoop: RTL and testbench



---
 rtl/ppu_rd_snoop.sv | 163 ++++++++++++++++
 tb/tb_ppu_rd_snoop.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_rd_snoop.sv
// PPU read-strobe snooper for CHR-latch mappers (MMC2/MMC4): filters glitch strobes,
// captures the fetch address mid-strobe and emits decoded latch-trigger pulses.
module ppu_rd_snoop #(
    parameter int SAMPLE_DLY    = 3,
    parameter int MIN_LOW       = 4,
    parameter int IDLE_CYC      = 1024,
    parameter bit LO_FULL_RANGE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppu_oe,
    input  logic [13:0] ppu_addr,
    input  logic        ss_act,
    output logic        rd_strb,
    output logic [13:0] rd_addr,
    output logic        lat0_clr,
    output logic        lat0_set,
    output logic        lat1_clr,
    output logic        lat1_set,
    output logic        ppu_idle,
    output logic [3:0]  glitch_cnt
);

    localparam int              IW       = $clog2(IDLE_CYC + 1);
    localparam logic [IW-1:0]   IDLE_MAX = IW'(IDLE_CYC);
    localparam logic [3:0]      SDLY     = 4'(SAMPLE_DLY);
    localparam logic [4:0]      MINL     = 5'(MIN_LOW);

    typedef enum logic {S_IDLE, S_LOW} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    settle_q, settle_d;
    logic          arm_q, arm_d;
    logic [3:0]    low_cnt_q, low_cnt_d;
    logic [13:0]   cap_addr_q, cap_addr_d;
    logic          rd_strb_q, rd_strb_d;
    logic [13:0]   rd_addr_q, rd_addr_d;
    logic          lat0_clr_q, lat0_clr_d;
    logic          lat0_set_q, lat0_set_d;
    logic          lat1_clr_q, lat1_clr_d;
    logic          lat1_set_q, lat1_set_d;
    logic [3:0]    glitch_q, glitch_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    logic oe_s;
    logic settled;
    logic hit_l0c, hit_l0s, hit_l1c, hit_l1s;

    assign oe_s    = sync2_q;
    assign settled = (settle_q == 2'd2);

    always_comb begin
        if (LO_FULL_RANGE) begin
            hit_l0c = (cap_addr_q[13:3] == 11'h1FB);
            hit_l0s = (cap_addr_q[13:3] == 11'h1FD);
        end else begin
            hit_l0c = (cap_addr_q == 14'h0FD8);
            hit_l0s = (cap_addr_q == 14'h0FE8);
        end
        hit_l1c = (cap_addr_q[13:3] == 11'h3FB);
        hit_l1s = (cap_addr_q[13:3] == 11'h3FD);
    end

    always_comb begin
        sync1_d  = ppu_oe;
        sync2_d  = sync1_q;
        // Synchronizer contents are reset artifacts for two cycles; only a genuinely
        // observed high arms the FSM, so a strobe held low across reset is ignored.
        settle_d = settled ? settle_q : settle_q + 2'd1;
        arm_d    = arm_q | (settled & oe_s);

        state_d    = state_q;
        low_cnt_d  = low_cnt_q;
        cap_addr_d = cap_addr_q;
        rd_strb_d  = 1'b0;
        rd_addr_d  = rd_addr_q;
        lat0_clr_d = 1'b0;
        lat0_set_d = 1'b0;
        lat1_clr_d = 1'b0;
        lat1_set_d = 1'b0;
        glitch_d   = glitch_q;

        case (state_q)
            S_IDLE: begin
                if (arm_q && !oe_s) begin
                    state_d   = S_LOW;
                    low_cnt_d = 4'd1;
                end
            end
            S_LOW: begin
                if (!oe_s) begin
                    if (low_cnt_q != 4'hF) low_cnt_d = low_cnt_q + 4'd1;
                    if (low_cnt_q == SDLY) cap_addr_d = ppu_addr;
                end else begin
                    state_d = S_IDLE;
                    if ({1'b0, low_cnt_q} >= MINL) begin
                        rd_strb_d  = 1'b1;
                        rd_addr_d  = cap_addr_q;
                        lat0_clr_d = hit_l0c & ~ss_act;
                        lat0_set_d = hit_l0s & ~ss_act;
                        lat1_clr_d = hit_l1c & ~ss_act;
                        lat1_set_d = hit_l1s & ~ss_act;
                    end else if (glitch_q != 4'hF) begin
                        glitch_d = glitch_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_strb_q)                    idle_cnt_d = '0;
        else if (idle_cnt_q == IDLE_MAX)  idle_cnt_d = idle_cnt_q;
        else                              idle_cnt_d = idle_cnt_q + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            settle_q   <= 2'd0;
            arm_q      <= 1'b0;
            low_cnt_q  <= 4'd0;
            cap_addr_q <= 14'd0;
            rd_strb_q  <= 1'b0;
            rd_addr_q  <= 14'd0;
            lat0_clr_q <= 1'b0;
            lat0_set_q <= 1'b0;
            lat1_clr_q <= 1'b0;
            lat1_set_q <= 1'b0;
            glitch_q   <= 4'd0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            settle_q   <= settle_d;
            arm_q      <= arm_d;
            low_cnt_q  <= low_cnt_d;
            cap_addr_q <= cap_addr_d;
            rd_strb_q  <= rd_strb_d;
            rd_addr_q  <= rd_addr_d;
            lat0_clr_q <= lat0_clr_d;
            lat0_set_q <= lat0_set_d;
            lat1_clr_q <= lat1_clr_d;
            lat1_set_q <= lat1_set_d;
            glitch_q   <= glitch_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign rd_strb    = rd_strb_q;
    assign rd_addr    = rd_addr_q;
    assign lat0_clr   = lat0_clr_q;
    assign lat0_set   = lat0_set_q;
    assign lat1_clr   = lat1_clr_q;
    assign lat1_set   = lat1_set_q;
    assign glitch_cnt = glitch_q;
    assign ppu_idle   = (idle_cnt_q == IDLE_MAX);

endmodule

// File: tb/tb_ppu_rd_snoop.sv
// Bench for ppu_rd_snoop: two instances (exact and full low-bank range) share stimulus;
// expectations come from a transaction-level model of the read rules.
module tb_ppu_rd_snoop;

    localparam int SD = 3;
    localparam int ML = 4;
    localparam int IC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ppu_oe;
    logic [13:0] ppu_addr;
    logic        ss_act;

    logic        s0, s1;
    logic [13:0] a0, a1;
    logic        c00, s00, c10, s10, c01, s01, c11, s11;
    logic        i0, i1;
    logic [3:0]  g0, g1;

    int checks = 0;
    int fails  = 0;
    bit chk_idle = 0;

    logic [13:0] last_addr;
    int          gcnt;

    always #5 clk = ~clk;

    ppu_rd_snoop #(.SAMPLE_DLY(SD), .MIN_LOW(ML), .IDLE_CYC(IC), .LO_FULL_RANGE(1'b0)) d0 (
        .clk(clk), .rst(rst), .ppu_oe(ppu_oe), .ppu_addr(ppu_addr), .ss_act(ss_act),
        .rd_strb(s0), .rd_addr(a0), .lat0_clr(c00), .lat0_set(s00), .lat1_clr(c10),
        .lat1_set(s10), .ppu_idle(i0), .glitch_cnt(g0));

    ppu_rd_snoop #(.SAMPLE_DLY(SD), .MIN_LOW(ML), .IDLE_CYC(IC), .LO_FULL_RANGE(1'b1)) d1 (
        .clk(clk), .rst(rst), .ppu_oe(ppu_oe), .ppu_addr(ppu_addr), .ss_act(ss_act),
        .rd_strb(s1), .rd_addr(a1), .lat0_clr(c01), .lat0_set(s01), .lat1_clr(c11),
        .lat1_set(s11), .ppu_idle(i1), .glitch_cnt(g1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_lat(input logic [13:0] a, input bit lfr, input bit ss);
        logic c0, t0, c1, t1;
        if (ss) return 4'b0;
        c0 = lfr ? (a >= 14'h0FD8 && a <= 14'h0FDF) : (a == 14'h0FD8);
        t0 = lfr ? (a >= 14'h0FE8 && a <= 14'h0FEF) : (a == 14'h0FE8);
        c1 = (a >= 14'h1FD8 && a <= 14'h1FDF);
        t1 = (a >= 14'h1FE8 && a <= 14'h1FEF);
        return {c0, t0, c1, t1};
    endfunction

    // One strobe of w clk on the pin; the address may switch to late after edge chg_at.
    // The address is sampled SD+1 synchronized-low cycles in, i.e. pin edge SD+3.
    task automatic do_read(input int w, input logic [13:0] addr, input logic [13:0] late,
                           input int chg_at, input bit ss);
        bit          valid;
        logic [13:0] cap;
        logic [13:0] exp_a;
        int          exp_g;
        bit          es;
        ppu_addr = addr;
        ss_act   = ss;
        ppu_oe   = 1'b0;
        for (int i = 1; i <= w; i++) begin
            step();
            if (i == chg_at) ppu_addr = late;
        end
        ppu_oe = 1'b1;
        valid  = (w >= ML);
        cap    = (chg_at != 0 && chg_at < SD + 3) ? late : addr;
        exp_a  = valid ? cap : last_addr;
        exp_g  = valid ? gcnt : ((gcnt < 15) ? gcnt + 1 : 15);
        for (int k = 1; k <= 5; k++) begin
            step();
            es = valid && (k == 3);
            chk("rd_strb_exact", 32'(s0), 32'(es));
            chk("rd_strb_full", 32'(s1), 32'(es));
            chk("lat_exact", 32'({c00, s00, c10, s10}), es ? 32'(exp_lat(cap, 1'b0, ss)) : 32'd0);
            chk("lat_full", 32'({c01, s01, c11, s11}), es ? 32'(exp_lat(cap, 1'b1, ss)) : 32'd0);
            if (k == 3 || k == 5) begin
                chk("rd_addr_exact", 32'(a0), 32'(exp_a));
                chk("rd_addr_full", 32'(a1), 32'(exp_a));
            end
            if (k == 5) begin
                chk("glitch_cnt_exact", 32'(g0), 32'(exp_g));
                chk("glitch_cnt_full", 32'(g1), 32'(exp_g));
            end
            if (chk_idle && (k == 3 || k == 4)) begin
                chk("ppu_idle_release_exact", 32'(i0), 32'(k == 3));
                chk("ppu_idle_release_full", 32'(i1), 32'(k == 3));
            end
        end
        last_addr = exp_a;
        gcnt      = exp_g;
        ss_act    = 1'b0;
    endtask

    logic [13:0] pick [12] = '{14'h0FD8, 14'h0FDB, 14'h0FE8, 14'h0FEF, 14'h0FE0, 14'h1FD8,
                               14'h1FDF, 14'h1FE8, 14'h1FEC, 14'h1FE7, 14'h1FF0, 14'h0000};

    initial begin
        logic [13:0] ra, rl;
        int          rw, rc;
        bit          es;

        rst = 1'b1; ppu_oe = 1'b1; ppu_addr = 14'd0; ss_act = 1'b0;
        last_addr = 14'd0; gcnt = 0;
        repeat (3) step();
        chk("reset_rd_strb", 32'({s0, s1}), 32'd0);
        chk("reset_lat", 32'({c00, s00, c10, s10, c01, s01, c11, s11}), 32'd0);
        chk("reset_rd_addr", 32'({a0, a1}), 32'd0);
        chk("reset_glitch", 32'({g0, g1}), 32'd0);
        chk("reset_idle", 32'({i0, i1}), 32'd0);
        rst = 1'b0;
        repeat (4) step();

        // Basic decode, exact vs full low-bank range, and the high bank.
        do_read(8, 14'h0FD8, 14'h0, 0, 1'b0);
        do_read(8, 14'h0FDB, 14'h0, 0, 1'b0);
        do_read(8, 14'h1FEC, 14'h0, 0, 1'b0);

        // Glitch strobes: count up then saturate.
        for (int n = 0; n < 20; n++) do_read(2, 14'h1FD8, 14'h0, 0, 1'b0);

        // Address moves after capture but before the rise.
        do_read(8, 14'h0FE8, 14'h0000, 7, 1'b0);

        // Save-state suppresses triggers only.
        do_read(8, 14'h1FD8, 14'h0, 0, 1'b1);

        // Back-to-back: one-clk high between two 6-clk strobes.
        ppu_addr = 14'h0FE8;
        ppu_oe   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            es = (c == 9) || (c == 16);
            chk("b2b_strb_exact", 32'(s0), 32'(es));
            chk("b2b_strb_full", 32'(s1), 32'(es));
            if (c == 9) begin
                chk("b2b_addr_a", 32'(a0), 32'h0FE8);
                chk("b2b_lat_a", 32'({c01, s01, c11, s11}), 32'(exp_lat(14'h0FE8, 1'b1, 1'b0)));
            end
            if (c == 16) begin
                chk("b2b_addr_b", 32'(a1), 32'h1FDC);
                chk("b2b_lat_b", 32'({c00, s00, c10, s10}), 32'(exp_lat(14'h1FDC, 1'b0, 1'b0)));
            end
            if (c == 6)  ppu_oe = 1'b1;
            if (c == 7)  begin ppu_oe = 1'b0; ppu_addr = 14'h1FDC; end
            if (c == 13) ppu_oe = 1'b1;
        end
        last_addr = 14'h1FDC;

        // Idle: strobe lands 2 edges before the window end; idle asserts IC+1 edges after it.
        do_read(8, 14'h0123, 14'h0, 0, 1'b0);
        repeat (IC - 2) step();
        chk("idle_before_exact", 32'(i0), 32'd0);
        chk("idle_before_full", 32'(i1), 32'd0);
        step();
        chk("idle_set_exact", 32'(i0), 32'd1);
        chk("idle_set_full", 32'(i1), 32'd1);
        chk_idle = 1'b1;
        do_read(6, 14'h1FE8, 14'h0, 0, 1'b0);
        chk_idle = 1'b0;

        // Reset in the middle of a strobe: that strobe must never be reported.
        ppu_addr = 14'h0FE8;
        ppu_oe   = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_addr = 14'd0; gcnt = 0;
        chk("midrst_rd_addr", 32'({a0, a1}), 32'd0);
        chk("midrst_glitch", 32'({g0, g1}), 32'd0);
        repeat (5) step();
        ppu_oe = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("midrst_no_strb", 32'({s0, s1}), 32'd0);
        end
        do_read(6, 14'h1FE8, 14'h0, 0, 1'b0);

        // Randomized reads against the transaction model.
        for (int n = 0; n < 40; n++) begin
            rw = $urandom_range(1, 10);
            ra = ($urandom_range(0, 3) == 0) ? 14'($urandom) : pick[$urandom_range(0, 11)];
            rl = 14'($urandom);
            rc = $urandom_range(0, rw);
            do_read(rw, ra, rl, rc, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
